spi_mem_bridge: RTL and testbench
=================================

SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning system clocks per SPI half-period (legal range 1..255).
REQ-002 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset, asynchronous, active-low; one clock only.
REQ-003 SHALL have ports: req_valid  in  1  CPU request strobe; req_ready  out  1  bridge idle, request accepted when both high.
REQ-004 SHALL have ports: req_we  in  1  1 = write, 0 = read; req_addr  in  16  byte address; req_wdata  in  8  write byte.
REQ-005 SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  8  read byte.
REQ-006 SHALL have ports: spi_cs_n  out  1  chip select; spi_clk  out  1  SPI clock; spi_mosi  out  1  master out; spi_miso  in  1  master in.

Function
REQ-007 SHALL implement SPI mode 0: spi_clk idles low; MOSI changes only while spi_clk low; MISO sampled on the system clock edge that drives spi_clk high.
REQ-008 SHALL use states IDLE -> CMD (8 bits) -> ADDR (16 bits) -> [DUMMY (8 bits)] -> DATA (8 bits) -> DONE -> IDLE.
REQ-009 SHALL assert req_ready only in IDLE; req_valid outside IDLE ignored, never queued.
REQ-010 SHALL capture req_we, req_addr, req_wdata at acceptance; later input changes ignored for that transaction.
REQ-011 SHALL send opcode 0x03 for reads and 0x02 for writes, then req_addr, then (write) req_wdata, all MSB first.
REQ-012 SHALL, for acceptance at edge N, drive spi_cs_n low and MOSI = opcode bit 7 from cycle N+1.
REQ-013 SHALL make every bit 2*CLK_DIV cycles: CLK_DIV cycles spi_clk low, then CLK_DIV cycles high.
REQ-014 SHALL drive spi_mosi 0 during DATA of reads and during DUMMY.
REQ-015 SHALL shift sampled MISO bits MSB first into resp_rdata during DATA of reads only.
REQ-016 SHALL, in DONE (cycle N+1+B*2*CLK_DIV, B = total bits), drive spi_cs_n high, spi_clk low, pulse resp_valid for exactly one cycle.
REQ-017 SHALL return to IDLE the cycle after DONE, guaranteeing spi_cs_n high for at least two cycles between transactions.
REQ-018 SHALL hold resp_rdata stable from resp_valid until the next read's DATA phase; write responses leave resp_rdata unchanged.
REQ-019 SHALL use one bit counter and one divide counter; no wrap beyond CLK_DIV-1 or the phase bit count.

Reset
REQ-020 SHALL, on rst_n low at any time including mid-transaction, immediately force: state IDLE, spi_cs_n 1, spi_clk 0, spi_mosi 0, resp_valid 0, resp_rdata 0x00, req_ready 0 while rst_n low.
REQ-021 SHALL assert req_ready on the first clock edge after rst_n deasserts; aborted transactions produce no resp_valid.

Configuration
REQ-022 SHALL honour macro SPI_MEM_FAST_READ_EN: when defined, reads use opcode 0x0B with an 8-bit DUMMY phase (B = 40); when undefined, reads use 0x03 with no DUMMY (B = 32); writes unaffected (B = 32).

Structure
REQ-023 SHALL take opcodes (0x02, 0x03, 0x0B), state enum, and address width 16 from shared package spi_mem_pkg.
REQ-024 SHALL place divider and phase strobes (rise/fall strobe, spi_clk level) in sub-module spi_clk_gen, parameterised by CLK_DIV.

Verification
REQ-025 SHALL cover: read addr 0x1234, model returns 0xA5, CLK_DIV=2, macro off -> MOSI 0x03,0x12,0x34; resp_rdata 0xA5; resp_valid at N+129.
REQ-026 SHALL cover: write addr 0xFFFF data 0x3C -> MOSI 0x02,0xFF,0xFF,0x3C; 32 spi_clk rising edges; resp_valid once; resp_rdata unchanged.
REQ-027 SHALL cover: macro on, read addr 0x0000, model returns 0x5A -> MOSI 0x0B,0x00,0x00,0x00 dummy; resp_rdata 0x5A at N+161.
REQ-028 SHALL cover: req_valid held high throughout a read -> second acceptance only after DONE+1; spi_cs_n high at least 2 cycles between.
REQ-029 SHALL cover: rst_n low at ADDR bit 5 -> spi_cs_n 1, spi_clk 0 same cycle; no resp_valid; new read after reset completes correctly.
REQ-030 SHALL cover: CLK_DIV=1 read -> spi_clk period 2 cycles, resp_valid at N+65, data correct.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory bridge: opcodes, address width,
// FSM state encoding and a per-phase bit-count helper.
package spi_mem_pkg;

    localparam int         ADDR_W       = 16;
    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_t;

    // Index of the last bit of a shifting phase (address is 16 bits, the rest 8).
    function automatic logic [3:0] phase_last_bit(input state_t st);
        case (st)
            ST_ADDR: return 4'd15;
            default: return 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/spi_mem_bridge_clk_gen.sv
// SPI clock generator: CLK_DIV system clocks low, then CLK_DIV high per bit.
// rise_stb marks the system edge that drives spi_clk high (MISO sample point),
// fall_stb marks the edge that drives it low again (end of a bit).
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic spi_clk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_reg;
    logic       level_reg;

    // Divide counter and spi_clk level; both park at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            level_reg   <= 1'b0;
        end else if (!en) begin
            div_cnt_reg <= '0;
            level_reg   <= 1'b0;
        end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            level_reg   <= ~level_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
        end
    end

    assign rise_stb = en && (div_cnt_reg == DIV_LAST) && !level_reg;
    assign fall_stb = en && (div_cnt_reg == DIV_LAST) &&  level_reg;
    assign spi_clk  = level_reg;

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI memory bridge: turns a single-byte CPU read/write into an SPI mode-0
// transaction (opcode, 16-bit address, optional dummy byte, data byte).
// Build option: define SPI_MEM_FAST_READ_EN to issue fast reads (0x0B plus
// one dummy byte) instead of plain reads (0x03).
module spi_mem_bridge
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              resp_valid,
    output logic [7:0]        resp_rdata,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

`ifdef SPI_MEM_FAST_READ_EN
    localparam bit FAST_READ = 1'b1;
`else
    localparam bit FAST_READ = 1'b0;
`endif

    state_t              state_reg, state_next;
    logic                ready_en_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [7:0]          wdata_reg;
    logic [3:0]          bit_cnt_reg;
    logic [7:0]          rdata_reg;

    logic                in_phase;
    logic                accept;
    logic                phase_end;
    logic                rise_stb;
    logic                fall_stb;
    logic [7:0]          opcode;

    assign in_phase  = (state_reg == ST_CMD)   || (state_reg == ST_ADDR) ||
                       (state_reg == ST_DUMMY) || (state_reg == ST_DATA);
    assign accept    = req_valid && req_ready;
    assign phase_end = fall_stb && (bit_cnt_reg == phase_last_bit(state_reg));
    assign opcode    = we_reg ? OP_WRITE : (FAST_READ ? OP_FAST_READ : OP_READ);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (in_phase),
        .spi_clk  (spi_clk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Ready stays low through reset and rises on the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    // Next-state: each shifting phase ends on the falling strobe of its last bit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept)    state_next = ST_CMD;
            ST_CMD:   if (phase_end) state_next = ST_ADDR;
            ST_ADDR:  if (phase_end) state_next = (FAST_READ && !we_reg) ? ST_DUMMY : ST_DATA;
            ST_DUMMY: if (phase_end) state_next = ST_DATA;
            ST_DATA:  if (phase_end) state_next = ST_DONE;
            ST_DONE:                 state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Request capture, shared bit counter and read-data shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            bit_cnt_reg <= '0;
            rdata_reg   <= '0;
        end else begin
            if (accept) begin
                we_reg    <= req_we;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (phase_end || !in_phase) begin
                bit_cnt_reg <= '0;
            end else if (fall_stb) begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
            if (rise_stb && (state_reg == ST_DATA) && !we_reg) begin
                rdata_reg <= {rdata_reg[6:0], spi_miso};
            end
        end
    end

    // Outputs: MOSI picks the current bit MSB-first from the active field.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        spi_cs_n   = 1'b1;
        spi_mosi   = 1'b0;
        case (state_reg)
            ST_IDLE: req_ready = ready_en_reg;
            ST_CMD: begin
                spi_cs_n = 1'b0;
                spi_mosi = opcode[~bit_cnt_reg[2:0]];
            end
            ST_ADDR: begin
                spi_cs_n = 1'b0;
                spi_mosi = addr_reg[~bit_cnt_reg];
            end
            ST_DUMMY: spi_cs_n = 1'b0;
            ST_DATA: begin
                spi_cs_n = 1'b0;
                spi_mosi = we_reg & wdata_reg[~bit_cnt_reg[2:0]];
            end
            ST_DONE: resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Testbench for spi_mem_bridge: one instance at CLK_DIV=2, one at CLK_DIV=1,
// each attached to a behavioural SPI memory slave. Directed table, reset
// abort sequence, then randomized transactions against a memory model.
`timescale 1ns/1ps
module tb_spi_mem_bridge;

`ifdef SPI_MEM_FAST_READ_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        int          d;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wd;
        bit          hold;
        logic [7:0]  exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       req_valid, req_ready, req_we, resp_valid;
    logic [1:0]       spi_cs_n, spi_clk, spi_mosi, spi_miso;
    logic [1:0][15:0] req_addr;
    logic [1:0][7:0]  req_wdata, resp_rdata;

    spi_mem_bridge #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .spi_cs_n(spi_cs_n[0]), .spi_clk(spi_clk[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0])
    );

    spi_mem_bridge #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .spi_cs_n(spi_cs_n[1]), .spi_clk(spi_clk[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1])
    );

    // ---------------- behavioural memory slave ----------------
    logic [7:0] mem [int];

    function automatic logic [7:0] mem_peek(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        if (a == 16'h1234) return 8'hA5;
        if (a == 16'h0000) return 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h69;
    endfunction

    function automatic int cdiv(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    int          nbits[2]     = '{0, 0};
    int          hdr[2]       = '{99, 99};
    int          snap_bits[2] = '{0, 0};
    int          resp_cnt[2]  = '{0, 0};
    int          resp_cyc[2]  = '{0, 0};
    int          last_rise[2] = '{0, 0};
    int          gap_bad[2]   = '{0, 0};
    int          hi_cnt[2]    = '{0, 0};
    int          hi_run[2]    = '{0, 0};
    logic        prev_sclk[2] = '{1'b0, 1'b0};
    logic        prev_cs[2]   = '{1'b1, 1'b1};
    logic [39:0] sh[2]        = '{40'h0, 40'h0};
    logic [39:0] snap_sh[2]   = '{40'h0, 40'h0};
    logic [7:0]  op_seen[2]   = '{8'h00, 8'h00};
    logic [15:0] adr_seen[2]  = '{16'h0, 16'h0};
    logic [7:0]  dbyte[2]     = '{8'h00, 8'h00};

    initial spi_miso = 2'b00;

    // Slave: captures MOSI on every spi_clk rise, serves the addressed byte MSB first.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (resp_valid[d] === 1'b1) begin
                resp_cnt[d]++;
                resp_cyc[d] = cyc;
            end
            if (spi_cs_n[d] !== 1'b0) begin
                if (!prev_cs[d]) begin
                    snap_bits[d] = nbits[d];
                    snap_sh[d]   = sh[d];
                end
                hi_cnt[d]++;
                nbits[d]     = 0;
                sh[d]        = '0;
                hdr[d]       = 99;
                op_seen[d]   = 8'h00;
                prev_sclk[d] = 1'b0;
                spi_miso[d]  = 1'b0;
                prev_cs[d]   = 1'b1;
            end else begin
                if (prev_cs[d]) begin
                    hi_run[d] = hi_cnt[d];
                    hi_cnt[d] = 0;
                end
                if (spi_clk[d] && !prev_sclk[d]) begin
                    if (nbits[d] > 0 && (cyc - last_rise[d]) != 2 * cdiv(d)) gap_bad[d]++;
                    last_rise[d] = cyc;
                    sh[d] = {sh[d][38:0], spi_mosi[d]};
                    nbits[d]++;
                    if (nbits[d] == 24) begin
                        op_seen[d]  = sh[d][23:16];
                        adr_seen[d] = sh[d][15:0];
                        hdr[d]      = (op_seen[d] == 8'h0B) ? 32 : 24;
                        dbyte[d]    = mem_peek(adr_seen[d]);
                    end
                    if (op_seen[d] != 8'h02 && nbits[d] >= hdr[d] && nbits[d] < hdr[d] + 8)
                        spi_miso[d] = dbyte[d][7 - (nbits[d] - hdr[d])];
                    else
                        spi_miso[d] = 1'b0;
                    if (op_seen[d] == 8'h02 && nbits[d] == 32)
                        mem[int'(adr_seen[d])] = sh[d][7:0];
                end
                prev_sclk[d] = spi_clk[d];
                prev_cs[d]   = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] last_rd[2]   = '{8'h00, 8'h00};
    bit         prev_hold[2] = '{1'b0, 1'b0};
    int         prev_resp[2] = '{0, 0};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int          d, cd, b, acc, r0, g0, lim;
        logic [7:0]  op;
        logic [39:0] exp_sh;
        bit          got;
        d  = v.d;
        cd = cdiv(d);
        op = v.we ? 8'h02 : (FAST ? 8'h0B : 8'h03);
        b  = (!v.we && FAST) ? 40 : 32;
        if (b == 40) exp_sh = {op, v.addr, 8'h00, 8'h00};
        else         exp_sh = {8'h00, op, v.addr, (v.we ? v.wd : 8'h00)};
        r0 = resp_cnt[d];
        g0 = gap_bad[d];
        req_we[d] = v.we; req_addr[d] = v.addr; req_wdata[d] = v.wd; req_valid[d] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (req_ready[d] === 1'b1) got = 1'b1;
            else step();
        end
        if (!got) begin
            check({tag, " accept"}, 64'd0, 64'd1);
            req_valid[d] = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (prev_hold[d]) check({tag, " accept gap after DONE"}, 64'(acc - prev_resp[d]), 64'd2);
        step();
        // inputs changing after acceptance must not affect this transaction
        req_we[d] = ~v.we; req_addr[d] = ~v.addr; req_wdata[d] = ~v.wd;
        if (!v.hold) req_valid[d] = 1'b0;
        check({tag, " cs_n at N+1"}, 64'(spi_cs_n[d]), 64'd0);
        check({tag, " mosi opcode msb"}, 64'(spi_mosi[d]), 64'(op[7]));
        check({tag, " ready busy"}, 64'(req_ready[d]), 64'd0);
        lim = b * 2 * cd + 10;
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            step();
            if (resp_cnt[d] != r0) got = 1'b1;
        end
        check({tag, " resp_valid seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, " latency"}, 64'(resp_cyc[d] - acc), 64'(b * 2 * cd));
            check({tag, " rdata"}, 64'(resp_rdata[d]), 64'(v.exp_rd));
            check({tag, " cs_n in DONE"}, 64'(spi_cs_n[d]), 64'd1);
            check({tag, " spi_clk in DONE"}, 64'(spi_clk[d]), 64'd0);
            check({tag, " rise count"}, 64'(snap_bits[d]), 64'(b));
            check({tag, " mosi stream"}, 64'(snap_sh[d]), 64'(exp_sh));
            check({tag, " bit period"}, 64'(gap_bad[d] - g0), 64'd0);
            check({tag, " cs_n high gap >= 2"}, 64'(hi_run[d] >= 2), 64'd1);
            step();
            check({tag, " resp_valid once"}, 64'(resp_cnt[d] - r0), 64'd1);
            check({tag, " rdata held"}, 64'(resp_rdata[d]), 64'(v.exp_rd));
        end
        prev_hold[d] = v.hold;
        prev_resp[d] = resp_cyc[d];
        last_rd[d]   = v.exp_rd;
    endtask

    vec_t tbl[9];

    initial begin
        int   r0;
        bit   got;
        vec_t v;
        bit   hold_pending;
        int   hold_d;

        tbl[0] = '{0, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hA5};
        tbl[1] = '{0, 1'b1, 16'hFFFF, 8'h3C, 1'b0, 8'hA5};
        tbl[2] = '{0, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'h3C};
        tbl[3] = '{0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h5A};
        tbl[4] = '{1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hA5};
        tbl[5] = '{1, 1'b1, 16'h8001, 8'h77, 1'b0, 8'hA5};
        tbl[6] = '{1, 1'b0, 16'h8001, 8'h00, 1'b0, 8'h77};
        tbl[7] = '{0, 1'b0, 16'h1234, 8'h00, 1'b1, 8'hA5};
        tbl[8] = '{0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h5A};

        rst_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset%0d cs_n", d), 64'(spi_cs_n[d]), 64'd1);
            check($sformatf("reset%0d spi_clk", d), 64'(spi_clk[d]), 64'd0);
            check($sformatf("reset%0d mosi", d), 64'(spi_mosi[d]), 64'd0);
            check($sformatf("reset%0d ready", d), 64'(req_ready[d]), 64'd0);
            check($sformatf("reset%0d resp_valid", d), 64'(resp_valid[d]), 64'd0);
            check($sformatf("reset%0d rdata", d), 64'(resp_rdata[d]), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        check("ready before first edge", 64'(req_ready[0]), 64'd0);
        step();
        check("ready after first edge", 64'(req_ready[0]), 64'd1);

        for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Abort a read in the middle of its address phase with reset.
        req_we[0] = 1'b0; req_addr[0] = 16'h4321; req_wdata[0] = 8'h00; req_valid[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (req_ready[0] === 1'b1) got = 1'b1;
            else step();
        end
        step();
        req_valid[0] = 1'b0;
        r0 = resp_cnt[0];
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (nbits[0] >= 14) got = 1'b1;
            else step();
        end
        check("abort reached addr bit 5", 64'(got), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort cs_n", 64'(spi_cs_n[0]), 64'd1);
        check("abort spi_clk", 64'(spi_clk[0]), 64'd0);
        check("abort mosi", 64'(spi_mosi[0]), 64'd0);
        check("abort ready", 64'(req_ready[0]), 64'd0);
        check("abort rdata", 64'(resp_rdata[0]), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("abort ready after release", 64'(req_ready[0]), 64'd1);
        repeat (3) step();
        check("abort no resp_valid", 64'(resp_cnt[0] - r0), 64'd0);
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        prev_hold[0] = 1'b0; prev_hold[1] = 1'b0;
        v = '{0, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hA5};
        run_txn(v, "post-reset read");

        // Randomized traffic against the memory model.
        hold_pending = 1'b0;
        hold_d = 0;
        for (int k = 0; k < 24; k++) begin
            v.d    = hold_pending ? hold_d : int'($urandom_range(0, 1));
            v.we   = 1'($urandom_range(0, 1));
            v.addr = 16'($urandom_range(0, 7)) * 16'h2111;
            if ($urandom_range(0, 2) == 0) v.addr = 16'($urandom);
            v.wd   = 8'($urandom);
            v.hold = (k < 23) && ($urandom_range(0, 3) == 0);
            v.exp_rd = v.we ? last_rd[v.d] : mem_peek(v.addr);
            hold_pending = v.hold;
            hold_d = v.d;
            run_txn(v, $sformatf("rnd%0d", k));
        end

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
